alu_cmp_seq: RTL and testbench

Sequential multi-cycle comparator in the ALU comparison path. It sits directly upstream of the comparison 6:1 result mux. It accepts operands a/b plus a 3-bit compare op, and compares MSB-first CHUNK bits per cycle. It then presents six N-bit result words (d0..d5) and the select code (sel) to the mux through a valid/ready handshake.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmp_seq_if.sv | 32 +++
 rtl/alu_cmp_seq_chunk.sv | 12 +
 rtl/alu_cmp_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_cmp_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU comparison path: compare op codes (which are
// also the select encoding of the downstream 6:1 result mux) and the
// sequencer state type.
package alu_pkg;

    typedef enum logic [2:0] {
        CMP_EQ  = 3'd2,
        CMP_NE  = 3'd3,
        CMP_LT  = 3'd4,
        CMP_GE  = 3'd5,
        CMP_LTU = 3'd6,
        CMP_GEU = 3'd7
    } cmp_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Codes 0 and 1 are not compare ops; they complete without a compare.
    function automatic logic op_is_valid(input logic [2:0] op);
        return op >= CMP_EQ;
    endfunction

endpackage

// File: rtl/alu_cmp_seq_if.sv
// Request/result bundle between the comparison requester, the sequential
// comparator and the result mux. master = requester/consumer side,
// slave = comparator side.
interface alu_cmp_seq_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   sel;
    logic [N-1:0] d0;
    logic [N-1:0] d1;
    logic [N-1:0] d2;
    logic [N-1:0] d3;
    logic [N-1:0] d4;
    logic [N-1:0] d5;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, sel, d0, d1, d2, d3, d4, d5
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, sel, d0, d1, d2, d3, d4, d5
    );
endinterface

// File: rtl/alu_cmp_seq_chunk.sv
// cmp_chunk: combinational W-bit unsigned magnitude compare of one chunk.
module cmp_chunk #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt,
    output logic         gt
);
    assign lt = (a < b);
    assign gt = (a > b);
endmodule

// File: rtl/alu_cmp_seq.sv
// alu_cmp_seq: sequential MSB-first comparator feeding the 6:1 compare
// result mux. CHUNK bits are compared per BUSY cycle; the first differing
// chunk freezes the unsigned decision. Signed ordering is derived from the
// operand sign bits plus the unsigned decision.
//
// Build option: define CMP_EARLY_EXIT_EN to leave BUSY on the first
// differing chunk; otherwise BUSY always lasts N/CHUNK cycles.
//
// N must be a multiple of CHUNK.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | walking chunks MSB-first, decision frozen at first difference
// DONE  | results presented with out_valid until out_ready
module alu_cmp_seq #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_cmp_seq_if.slave bus
);
    import alu_pkg::*;

    localparam int NCH = N / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    cmp_state_t   state, state_n;
    // Operands are shifted left each BUSY cycle so the active chunk is
    // always the top CHUNK bits; the sign bits are kept separately.
    logic [N-1:0] a_sh, a_sh_n;
    logic [N-1:0] b_sh, b_sh_n;
    logic         sa, sa_n;
    logic         sb, sb_n;
    logic [2:0]   op_q, op_n;
    logic [2:0]   sel_q, sel_n;
    logic [IW-1:0] idx, idx_n;
    logic         lt_u, lt_u_n;
    logic         gt_u, gt_u_n;
    logic [5:0]   d_q, d_n;

    logic         c_lt, c_gt;
    logic         undecided;
    logic         lt_u_c, gt_u_c;
    logic         eq_c, lt_s_c;
    logic         leave;

    cmp_chunk #(.W(CHUNK)) u_chunk (
        .a  (a_sh[N-1 -: CHUNK]),
        .b  (b_sh[N-1 -: CHUNK]),
        .lt (c_lt),
        .gt (c_gt)
    );

    assign undecided = !lt_u && !gt_u;
    assign lt_u_c    = lt_u || (undecided && c_lt);
    assign gt_u_c    = gt_u || (undecided && c_gt);
    assign eq_c      = !lt_u_c && !gt_u_c;
    assign lt_s_c    = (sa != sb) ? sa : lt_u_c;

`ifdef CMP_EARLY_EXIT_EN
    assign leave = (idx == '0) || (undecided && (c_lt || c_gt));
`else
    assign leave = (idx == '0);
`endif

    // Next-state and next-register values; flush overrides everything.
    always_comb begin
        state_n = state;
        a_sh_n  = a_sh;
        b_sh_n  = b_sh;
        sa_n    = sa;
        sb_n    = sb;
        op_n    = op_q;
        sel_n   = sel_q;
        idx_n   = idx;
        lt_u_n  = lt_u;
        gt_u_n  = gt_u;
        d_n     = d_q;

        if (bus.flush) begin
            state_n = IDLE;
            a_sh_n  = '0;
            b_sh_n  = '0;
            sa_n    = 1'b0;
            sb_n    = 1'b0;
            op_n    = '0;
            sel_n   = '0;
            idx_n   = '0;
            lt_u_n  = 1'b0;
            gt_u_n  = 1'b0;
            d_n     = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_n = bus.op;
                        if (op_is_valid(bus.op)) begin
                            a_sh_n  = bus.a;
                            b_sh_n  = bus.b;
                            sa_n    = bus.a[N-1];
                            sb_n    = bus.b[N-1];
                            idx_n   = IW'(NCH - 1);
                            lt_u_n  = 1'b0;
                            gt_u_n  = 1'b0;
                            state_n = BUSY;
                        end else begin
                            // Non-compare codes complete immediately with
                            // all-zero results.
                            sel_n   = bus.op;
                            d_n     = '0;
                            state_n = DONE;
                        end
                    end
                end
                BUSY: begin
                    lt_u_n = lt_u_c;
                    gt_u_n = gt_u_c;
                    a_sh_n = a_sh << CHUNK;
                    b_sh_n = b_sh << CHUNK;
                    if (idx != '0) begin
                        idx_n = idx - IW'(1);
                    end
                    if (leave) begin
                        d_n     = {!lt_u_c, lt_u_c, !lt_s_c, lt_s_c, !eq_c, eq_c};
                        sel_n   = op_q;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            op_q  <= '0;
            sel_q <= '0;
            idx   <= '0;
            lt_u  <= 1'b0;
            gt_u  <= 1'b0;
            d_q   <= '0;
        end else begin
            state <= state_n;
            a_sh  <= a_sh_n;
            b_sh  <= b_sh_n;
            sa    <= sa_n;
            sb    <= sb_n;
            op_q  <= op_n;
            sel_q <= sel_n;
            idx   <= idx_n;
            lt_u  <= lt_u_n;
            gt_u  <= gt_u_n;
            d_q   <= d_n;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.sel       = sel_q;
    assign bus.d0        = N'(d_q[0]);
    assign bus.d1        = N'(d_q[1]);
    assign bus.d2        = N'(d_q[2]);
    assign bus.d3        = N'(d_q[3]);
    assign bus.d4        = N'(d_q[4]);
    assign bus.d5        = N'(d_q[5]);

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Bench for alu_cmp_seq: a latency/result model built from plain
// arithmetic, a per-cycle compare process, and directed vectors with
// hand-computed expectations.
module tb_alu_cmp_seq;
    localparam int N     = 8;
    localparam int CHUNK = 2;
    localparam int NCH   = N / CHUNK;
`ifdef CMP_EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif
    localparam int LAT_MSB = EARLY ? 1 : 4;
    localparam int LAT_C2  = EARLY ? 3 : 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    alu_cmp_seq_if #(.N(N)) bus ();

    alu_cmp_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] dvec();
        return {bus.d5[0], bus.d4[0], bus.d3[0], bus.d2[0], bus.d1[0], bus.d0[0]};
    endfunction

    // Number of BUSY cycles from the operands alone.
    function automatic int model_lat(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] mask;
        mask = N'((1 << CHUNK) - 1);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (((a >> (i * CHUNK)) & mask) != ((b >> (i * CHUNK)) & mask))
                return EARLY ? (NCH - i) : NCH;
        end
        return NCH;
    endfunction

    // {d5..d0} from plain comparisons.
    function automatic logic [5:0] model_res(input logic [N-1:0] a, input logic [N-1:0] b);
        logic eq, ltu, lts;
        eq  = (a == b);
        ltu = (a < b);
        lts = ($signed(a) < $signed(b));
        return {!ltu, ltu, !lts, lts, !eq, eq};
    endfunction

    logic       m_ready = 1'b1;
    logic       m_valid = 1'b0;
    logic [2:0] m_sel   = '0;
    logic [5:0] m_d     = '0;
    logic [2:0] p_sel   = '0;
    logic [5:0] p_d     = '0;
    int         m_wait  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_sel <= '0; m_d <= '0; m_wait <= 0;
        end else if (bus.flush) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_sel <= '0; m_d <= '0; m_wait <= 0;
        end else if (m_ready) begin
            if (bus.in_valid) begin
                m_ready <= 1'b0;
                if (bus.op < 3'd2) begin
                    m_valid <= 1'b1;
                    m_sel   <= bus.op;
                    m_d     <= '0;
                end else begin
                    m_wait <= model_lat(bus.a, bus.b);
                    p_sel  <= bus.op;
                    p_d    <= model_res(bus.a, bus.b);
                end
            end
        end else if (m_wait > 1) begin
            m_wait <= m_wait - 1;
        end else if (m_wait == 1) begin
            m_wait  <= 0;
            m_valid <= 1'b1;
            m_sel   <= p_sel;
            m_d     <= p_d;
        end else if (m_valid && bus.out_ready) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
        end
    end

    always @(negedge clk) begin
        check("cyc.in_ready", 32'(bus.in_ready), 32'(m_ready));
        check("cyc.out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("cyc.sel", 32'(bus.sel), 32'(m_sel));
        check("cyc.d0", 32'(bus.d0), 32'(m_d[0]));
        check("cyc.d1", 32'(bus.d1), 32'(m_d[1]));
        check("cyc.d2", 32'(bus.d2), 32'(m_d[2]));
        check("cyc.d3", 32'(bus.d3), 32'(m_d[3]));
        check("cyc.d4", 32'(bus.d4), 32'(m_d[4]));
        check("cyc.d5", 32'(bus.d5), 32'(m_d[5]));
    end

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic issue_and_wait(input string nm, input logic [2:0] op,
                                  input logic [N-1:0] a, input logic [N-1:0] b,
                                  input int exp_lat, input logic [2:0] exp_sel,
                                  input logic [5:0] exp_d);
        int cyc;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(cyc);
        check({nm, ".lat"}, 32'(cyc), 32'(exp_lat));
        check({nm, ".sel"}, 32'(bus.sel), 32'(exp_sel));
        check({nm, ".d"}, 32'(dvec()), 32'(exp_d));
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.sel", 32'(bus.sel), 32'd0);
        check("rst.d", 32'(dvec()), 32'd0);
        #2 rst_n = 1'b1;

        // signed LT, MSB chunk differs
        issue_and_wait("t1", 3'd4, 8'h80, 8'h7F, LAT_MSB, 3'd4, 6'b100110);
        handshake(1);
        // EQ, equal operands
        issue_and_wait("t2", 3'd2, 8'h5A, 8'h5A, 4, 3'd2, 6'b101001);
        handshake(0);
        // signed GE, sign bits differ the other way
        issue_and_wait("tge", 3'd5, 8'h7F, 8'h80, LAT_MSB, 3'd5, 6'b011010);
        handshake(2);
        // differ in the third chunk from the MSB
        issue_and_wait("tmid", 3'd4, 8'h34, 8'h38, LAT_C2, 3'd4, 6'b010110);
        handshake(0);
        // LTU, only the last chunk differs
        issue_and_wait("t3", 3'd6, 8'h12, 8'h13, 4, 3'd6, 6'b010110);

        // results held in DONE while a second request waits
        bus.in_valid = 1'b1; bus.op = 3'd3; bus.a = 8'hC0; bus.b = 8'hC1;
        repeat (5) begin
            @(negedge clk);
            check("t4.in_ready", 32'(bus.in_ready), 32'd0);
            check("t4.out_valid", 32'(bus.out_valid), 32'd1);
            check("t4.d", 32'(dvec()), 32'(6'b010110));
            check("t4.sel", 32'(bus.sel), 32'd6);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("t4.idle", 32'(bus.in_ready), 32'd1);
        check("t4.keep_d", 32'(dvec()), 32'(6'b010110));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t4.taken", 32'(bus.in_ready), 32'd0);
        wait_valid(cyc);
        check("t4.lat", 32'(cyc), 32'd4);
        check("t4.sel2", 32'(bus.sel), 32'd3);
        check("t4.d2", 32'(dvec()), 32'(6'b010110));
        handshake(0);

        // non-compare codes
        issue_and_wait("t5op0", 3'd0, 8'h11, 8'h22, 0, 3'd0, 6'b000000);
        handshake(1);
        issue_and_wait("t5op1", 3'd1, 8'h33, 8'h33, 0, 3'd1, 6'b000000);
        handshake(0);

        // flush in BUSY
        issue_and_wait("tpre", 3'd5, 8'h7F, 8'h80, LAT_MSB, 3'd5, 6'b011010);
        handshake(0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd2; bus.a = 8'h33; bus.b = 8'h33;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("t5f.busy", 32'(bus.in_ready), 32'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("t5f.idle", 32'(bus.in_ready), 32'd1);
        check("t5f.sel", 32'(bus.sel), 32'd0);
        check("t5f.d", 32'(dvec()), 32'd0);
        // request alongside flush in IDLE is not taken
        bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 3'd2;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        check("t5f.no_take", 32'(bus.in_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            check("t5f.no_valid", 32'(bus.out_valid), 32'd0);
        end

        // reset mid-BUSY
        issue_and_wait("tpre2", 3'd5, 8'h7F, 8'h80, LAT_MSB, 3'd5, 6'b011010);
        handshake(0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = 3'd2; bus.a = 8'h5A; bus.b = 8'h5A;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.in_ready", 32'(bus.in_ready), 32'd1);
        check("t6.out_valid", 32'(bus.out_valid), 32'd0);
        check("t6.sel", 32'(bus.sel), 32'd0);
        check("t6.d", 32'(dvec()), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t6.ready", 32'(bus.in_ready), 32'd1);
        issue_and_wait("t6geu", 3'd7, 8'h01, 8'h02, 4, 3'd7, 6'b010110);
        handshake(0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
